// File: rtl/pulse_stretcher_pkg.sv
// rtl/pulse_stretcher_pkg.sv - shared state encoding and width helpers for pulse output blocks
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold max(a,b)-1, never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int w;
    w = clog2(max_int(a, b));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// rtl/pulse_timer.sv - loadable down-counter with count enable and zero flag
// Holds at zero instead of wrapping; every phase reloads it on entry.
module pulse_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         cen,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cen && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches press ticks into ON-high / GAP-low output pulses
// Optional PULSE_QUEUE_EN macro adds a saturating pending-tick queue; otherwise busy ticks are dropped.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int ON_CYCLES   = 10,
  parameter int GAP_CYCLES  = 10,
  parameter int MAX_PENDING = 3,
  localparam int PW = clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  output logic          pulse,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  localparam int TW = cnt_width(ON_CYCLES, GAP_CYCLES);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  state_t          state;
  logic            zero;
  logic            gap_end;
  logic            busy_tick;
  logic            restart;
  logic            tim_load;
  logic            tim_cen;
  logic [TW-1:0]   tim_val;
  logic            ovf_next;
  logic [PW-1:0]   pend;

  // The last GAP cycle is not "busy": a tick there starts the next pulse directly.
  assign gap_end   = (state == S_GAP) && zero;
  assign busy_tick = tick && ((state == S_ON) || ((state == S_GAP) && !zero));
  assign restart   = gap_end && ((pend != '0) || tick);

  assign tim_load = ((state == S_IDLE) && tick) || ((state == S_ON) && zero) || restart;
  assign tim_val  = (state == S_ON) ? GAP_LOAD : ON_LOAD;
  assign tim_cen  = (state != S_IDLE);

  pulse_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tim_load),
    .load_val (tim_val),
    .cen      (tim_cen),
    .zero     (zero)
  );

`ifdef PULSE_QUEUE_EN
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

  assign ovf_next = busy_tick && (pend == PEND_MAX);

  // A tick arriving with a dequeue at the GAP end replaces the dequeued slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else if (busy_tick && (pend != PEND_MAX)) begin
      pend <= pend + PW'(1);
    end else if (gap_end && (pend != '0) && !tick) begin
      pend <= pend - PW'(1);
    end
  end
`else
  assign ovf_next = busy_tick;
  assign pend     = '0;
`endif

  assign pending = pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pulse    <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= ovf_next;
      case (state)
        S_IDLE: begin
          if (tick) begin
            state <= S_ON;
            pulse <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_ON: begin
          if (zero) begin
            state <= S_GAP;
            pulse <= 1'b0;
          end
        end
        S_GAP: begin
          if (restart) begin
            state <= S_ON;
            pulse <= 1'b1;
          end else if (zero) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          pulse <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - self-checking bench for pulse_stretcher (ON=4, GAP=2, MAX_PENDING=2)
// Adapts its expectations to whether PULSE_QUEUE_EN is defined.
module tb_pulse_stretcher;

  localparam int ON   = 4;
  localparam int GAP  = 2;
  localparam int MAXP = 2;
`ifdef PULSE_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       tick;
  logic       pulse;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  pulse_stretcher #(
    .ON_CYCLES   (ON),
    .GAP_CYCLES  (GAP),
    .MAX_PENDING (MAXP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .pulse    (pulse),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: position k (cycles since the current pulse started) within an ON+GAP period.
  bit m_act;
  int m_k;
  int m_pend;
  bit m_ovf;

  task automatic model_reset();
    m_act = 0; m_k = 0; m_pend = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit t);
    m_ovf = 0;
    if (!m_act) begin
      if (t) begin m_act = 1; m_k = 0; end
    end else if (m_k == ON + GAP - 1) begin
      if (m_pend > 0) begin
        m_k = 0;
        if (!t) m_pend--;
      end else if (t) begin
        m_k = 0;
      end else begin
        m_act = 0;
      end
    end else begin
      m_k++;
      if (t) begin
        if (QEN && m_pend < MAXP) m_pend++;
        else m_ovf = 1;
      end
    end
  endtask

  task automatic check(input string name, input bit p, input bit b, input int pd, input bit o);
    tests++;
    if (pulse !== p || busy !== b || overflow !== o || $isunknown(pending) || int'(pending) != pd) begin
      fails++;
      $display("FAIL %s: got pulse=%b busy=%b pending=%0d overflow=%b, expected pulse=%b busy=%b pending=%0d overflow=%b",
               name, pulse, busy, pending, overflow, p, b, pd, o);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_act && (m_k < ON), m_act, m_pend, m_ovf);
  endtask

  // Drive at negedge, let one posedge happen, sample at the next negedge.
  task automatic step(input bit t);
    tick = t;
    @(posedge clk);
    model_step(t);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    tick = 1'b0;
    rst  = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit tick;
    bit p;
    bit b;
    int pd;
    bit o;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit t, input bit p, input bit b, input int pd, input bit o);
    vec_t v;
    v.tick = t; v.p = p; v.b = b; v.pd = pd; v.o = o;
    return v;
  endfunction

  task automatic run_table(input string name);
    foreach (tbl[i]) begin
      step(tbl[i].tick);
      check($sformatf("%s[%0d]", name, i), tbl[i].p, tbl[i].b, tbl[i].pd, tbl[i].o);
    end
    tbl.delete();
  endtask

  initial begin
    tick = 1'b0;
    rst  = 1'b1;
    model_reset();

    // Reset held for 3 cycles, then idle with no ticks.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("in_reset%0d", i), 0, 0, 0, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(0);
      check($sformatf("idle%0d", i), 0, 0, 0, 0);
    end

    // Single tick from IDLE.
    tbl.push_back(mk(1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0));
    run_table("single");

    // Four ticks back to back: first starts, rest are busy ticks.
    reset_dut();
    if (QEN) begin
      tbl.push_back(mk(1, 1, 1, 0, 0));
      tbl.push_back(mk(1, 1, 1, 1, 0));
      tbl.push_back(mk(1, 1, 1, 2, 0));
      tbl.push_back(mk(1, 1, 1, 2, 1));
      tbl.push_back(mk(0, 0, 1, 2, 0));
      tbl.push_back(mk(0, 0, 1, 2, 0));
      for (int r = 1; r >= 0; r--) begin
        for (int i = 0; i < ON; i++) tbl.push_back(mk(0, 1, 1, r, 0));
        for (int i = 0; i < GAP; i++) tbl.push_back(mk(0, 0, 1, r, 0));
      end
      tbl.push_back(mk(0, 0, 0, 0, 0));
      run_table("queue");
    end else begin
      tbl.push_back(mk(1, 1, 1, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 1));
      tbl.push_back(mk(1, 1, 1, 0, 1));
      tbl.push_back(mk(1, 1, 1, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0));
      run_table("noqueue");
    end

    // Tick on the last GAP cycle with nothing pending restarts immediately.
    reset_dut();
    step(1);
    for (int i = 0; i < ON + GAP - 1; i++) step(0);
    check("gap_last_before", 0, 1, 0, 0);
    step(1);
    check("gap_end_tick", 1, 1, 0, 0);
    for (int i = 0; i < ON - 1; i++) step(0);
    check("gap_end_pulse_len", 1, 1, 0, 0);
    step(0);
    check("gap_end_pulse_fall", 0, 1, 0, 0);

    // Tick on the last GAP cycle with a full queue.
    if (QEN) begin
      reset_dut();
      step(1); step(1); step(1);
      check("full_before", 1, 1, 2, 0);
      for (int i = 0; i < ON + GAP - 3; i++) step(0);
      check("full_gap_last", 0, 1, 2, 0);
      step(1);
      check("full_gap_end_tick", 1, 1, 2, 0);
    end

    // Asynchronous reset in the middle of the second ON cycle.
    reset_dut();
    step(1);
    step(1);
    check("pre_rst", 1, 1, QEN ? 1 : 0, QEN ? 0 : 1);
    #2 rst = 1'b1;
    #1 check("async_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      step(0);
      check($sformatf("post_rst%0d", i), 0, 0, 0, 0);
    end

    // Random ticks against the reference model, with occasional resets.
    reset_dut();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_reset();
        #1 check($sformatf("rand_rst%0d", i), 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
      end
      step($urandom_range(0, 2) == 0);
      check_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
